// File: rtl/div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl_if
// Description : EX-stage <-> divide sequencer bundle. The master (EX) issues
//               operands/start/annul; the slave (div_ctrl) returns the
//               {remainder, quotient} result, ready and stall request.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Multi-cycle radix-2 shift-subtract divide sequencer for the
//               EX stage. Works on operand magnitudes, one quotient bit per
//               cycle, then applies the MIPS sign correction. Raises a stall
//               request while a divide is in flight and aborts on annul.
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    div_ctrl_if.slave      bus
);

    localparam int              CNT_W  = $clog2(DATA_W) + 1;
    localparam int              WORK_W = 2 * DATA_W + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [WORK_W-1:0]      r_work;
    logic [WORK_W-1:0]      w_work_nxt;
    logic [DATA_W-1:0]      r_dvs_mag;
    logic [DATA_W-1:0]      w_dvs_mag_nxt;
    logic                   r_q_neg;
    logic                   w_q_neg_nxt;
    logic                   r_r_neg;
    logic                   w_r_neg_nxt;
    logic [2*DATA_W-1:0]    r_result;
    logic [2*DATA_W-1:0]    w_result_nxt;
    logic                   r_ready;
    logic                   w_ready_nxt;

    logic                   w_start_ok;
    logic                   w_dvd_neg;
    logic                   w_dvs_neg;
    logic [DATA_W-1:0]      w_dvd_mag_in;
    logic [DATA_W-1:0]      w_dvs_mag_in;
    logic [DATA_W:0]        w_diff;
    logic [DATA_W-1:0]      w_q_raw;
    logic [DATA_W-1:0]      w_r_raw;
    logic [DATA_W-1:0]      w_q_fix;
    logic [DATA_W-1:0]      w_r_fix;

    // An annul in IDLE suppresses the start request.
    assign w_start_ok   = bus.start_i & ~bus.annul_i;

    // Operand signs only matter for DIV; DIVU treats the MSB as magnitude.
    assign w_dvd_neg    = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign w_dvs_neg    = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign w_dvd_mag_in = w_dvd_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign w_dvs_mag_in = w_dvs_neg ? -bus.opdata2_i : bus.opdata2_i;

    // One extra bit so the borrow shows up as the sign of the trial subtract.
    assign w_diff  = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_dvs_mag};

    // Quotient bits accumulate at the bottom; the partial remainder ends up
    // one position above the quotient because of the initial left shift.
    assign w_q_raw = r_work[DATA_W-1:0];
    assign w_r_raw = r_work[2*DATA_W:DATA_W+1];
    assign w_q_fix = r_q_neg ? -w_q_raw : w_q_raw;
    assign w_r_fix = r_r_neg ? -w_r_raw : w_r_raw;

    assign bus.result_o   = r_result;
    assign bus.ready_o    = r_ready;
    assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~r_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values; everything holds unless changed.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_work_nxt    = r_work;
        w_dvs_mag_nxt = r_dvs_mag;
        w_q_neg_nxt   = r_q_neg;
        w_r_neg_nxt   = r_r_neg;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start_ok) begin
                    w_q_neg_nxt   = w_dvd_neg ^ w_dvs_neg;
                    w_r_neg_nxt   = w_dvd_neg;
                    w_dvs_mag_nxt = w_dvs_mag_in;
                    if (bus.opdata2_i == '0) begin
                        w_state_nxt = ST_BYZERO;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_work_nxt  = {{DATA_W{1'b0}}, w_dvd_mag_in, 1'b0};
                    end
                end
            end

            ST_BYZERO: begin
                // Divide by zero: no trap, result pinned to zero.
                w_result_nxt = '0;
                if (bus.annul_i) begin
                    w_state_nxt = ST_IDLE;
                    w_ready_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_ready_nxt = 1'b1;
                end
            end

            ST_RUN: begin
                // Annul takes priority, including on the completion edge.
                if (bus.annul_i) begin
                    w_state_nxt  = ST_IDLE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end else if (r_cnt == C_LAST) begin
                    w_state_nxt  = ST_DONE;
                    w_ready_nxt  = 1'b1;
                    w_result_nxt = {w_r_fix, w_q_fix};
                end else begin
                    if (w_diff[DATA_W]) begin
                        w_work_nxt = {r_work[2*DATA_W-1:0], 1'b0};
                    end else begin
                        w_work_nxt = {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end

            ST_DONE: begin
                // Result stays up until EX drops start (annul counts as a drop).
                if (!bus.start_i || bus.annul_i) begin
                    w_state_nxt  = ST_IDLE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_ready_nxt  = 1'b0;
                w_result_nxt = '0;
            end
        endcase
    end

    // Datapath registers, cleared asynchronously so a reset aborts at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_work    <= '0;
            r_dvs_mag <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_work    <= w_work_nxt;
            r_dvs_mag <= w_dvs_mag_nxt;
            r_q_neg   <= w_q_neg_nxt;
            r_r_neg   <= w_r_neg_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Directed self-checking bench for div_ctrl with hand-computed
//               quotient/remainder vectors, latency, annul and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    int   n_fail;

    div_ctrl_if #(.DATA_W(32)) bus ();

    div_ctrl #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts passes and failures.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide, scramble operands after the start edge, measure the
    // latency and stall cycles, check the result, optionally release start.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input int exp_lat, input logic drop);
        int lat;
        int stalls;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        #1 chk({tag, "_stall_rise"}, 64'(bus.stallreq_o), 64'd1);
        @(posedge clk);
        #1;
        lat    = 0;
        stalls = 0;
        while (!bus.ready_o && lat < 40) begin
            if (bus.stallreq_o) stalls++;
            if (lat == 0) begin
                bus.signed_div_i = ~sgn;
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
        chk({tag, "_result"}, bus.result_o, exp_res);
        chk({tag, "_stall_done"}, 64'(bus.stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
        chk({tag, "_hold_result"}, bus.result_o, exp_res);
        if (drop) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            @(posedge clk);
            #1;
            chk({tag, "_release_ready"}, 64'(bus.ready_o), 64'd0);
            chk({tag, "_release_result"}, bus.result_o, 64'd0);
        end
    endtask

    initial begin
        logic seen;
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready",  64'(bus.ready_o),    64'd0);
        chk("reset_result", bus.result_o,        64'd0);
        chk("reset_stall",  64'(bus.stallreq_o), 64'd0);
        bus.start_i = 1'b1;
        #1 chk("reset_stall_eq", 64'(bus.stallreq_o), 64'd1);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Main function vectors
        run_div("divu_7_2",   1'b0, 32'd7,         32'd2,         64'h00000001_00000003, 33, 1'b1);
        run_div("div_m7_2",   1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 33, 1'b1);
        run_div("div_7_m2",   1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33, 1'b1);
        run_div("div_m100_m7",1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 33, 1'b1);
        run_div("div_ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33, 1'b1);
        run_div("divu_max_1", 1'b0, 32'hFFFFFFFF,  32'h00000001,  64'h00000000_FFFFFFFF, 33, 1'b1);
        run_div("div_by_zero",1'b1, 32'h12345678,  32'h00000000,  64'd0,                  1, 1'b1);

        // Annul at cnt=10
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        #1 chk("annul_stall_drop", 64'(bus.stallreq_o), 64'd0);
        @(posedge clk);
        #1 chk("annul_ready", 64'(bus.ready_o), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) seen = 1'b1;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1);

        // Annul on the completion edge
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd9;
        bus.opdata2_i    = 32'd4;
        bus.start_i      = 1'b1;
        @(posedge clk);
        repeat (32) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("annul_last_ready",  64'(bus.ready_o), 64'd0);
        chk("annul_last_result", bus.result_o,     64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk);

        // Reset mid-RUN, between edges
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd50;
        bus.opdata2_i    = 32'd5;
        bus.start_i      = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_run_ready",  64'(bus.ready_o), 64'd0);
        chk("rst_run_result", bus.result_o,     64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_div("after_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);

        // Reset while holding a result in DONE clears it asynchronously
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_done_ready",  64'(bus.ready_o), 64'd0);
        chk("rst_done_result", bus.result_o,     64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_div("final_divu", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 33, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle integer divide sequencer for the EX stage. It latches the operands of a DIV/DIVU issued by EX and runs a radix-2 shift-subtract iteration, one quotient bit per cycle. It applies the MIPS sign correction and returns {remainder, quotient} for the HI/LO write. While the divide is in flight it raises a stall request to the pipeline controller, and it aborts on annul (flush).

## Interface
- DATA_W, 32, operand width; result is 2*DATA_W; iteration counter is clog2(DATA_W)+1 bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- start_i  in  1  request from EX; held high until the result is consumed
- annul_i  in  1  flush: abandon the current divide
- result_o  out  2*DATA_W  {remainder, quotient}; valid only while ready_o=1
- ready_o  out  1  registered; result valid
- stallreq_o  out  1  combinational: start_i & ~annul_i & ~ready_o

## Operation
- The sequencer has four states: IDLE, BYZERO, RUN and DONE.
- **IDLE**
  - On start_i=1 & annul_i=0, latch signed_div_i and the operand magnitudes. A magnitude is the two's-complement negation of the operand when signed_div_i=1 and its MSB=1, otherwise the raw operand.
  - If opdata2_i==0, go to BYZERO.
  - Otherwise go to RUN with cnt=0 and work register W (2*DATA_W+1 bits) = {0, |dividend|, 1'b0}.
- **RUN, cnt<DATA_W**
  - diff = W[2*DATA_W-1:DATA_W] - |divisor|, computed DATA_W+1 bits wide.
  - If diff is negative, W <= {W[2*DATA_W-1:0], 0}; otherwise W <= {diff[DATA_W-1:0], W[DATA_W-1:0], 1}.
  - cnt <= cnt+1.
- **RUN, cnt==DATA_W**
  - Raw quotient q = W[DATA_W-1:0]; raw remainder r = W[2*DATA_W:DATA_W+1].
  - If signed and the dividend and divisor signs differ, q <= -q. If signed and the dividend is negative, r <= -r.
  - result_o <= {r, q}, ready_o <= 1, go to DONE.
- **BYZERO**
  - result_o <= 0, ready_o <= 1, go to DONE. No exception is raised; the architectural result is undefined and is fixed at 0.
- **DONE**
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0, go to IDLE with ready_o <= 0 and result_o <= 0.
- **Annul**: annul_i=1 in RUN or BYZERO sends the block to IDLE at the next edge with ready_o=0 and result_o=0. annul_i in IDLE blocks the start. annul_i in DONE is treated as start_i=0.
- **Operand changes**: changes on opdata*_i or signed_div_i after the start edge have no effect.
- **Overflow case**: signed 0x80000000 / 0xFFFFFFFF wraps to q=0x80000000, r=0, with no trap.

## Timing
- **Reset**: state=IDLE, cnt=0, W=0, result_o=0, ready_o=0. stallreq_o follows its equation (0 when start_i=0). Reset asserted mid-RUN aborts immediately and asynchronously.
- **Divide latency**: start_i first sampled at edge N gives RUN from N, iterations at edges N+1..N+DATA_W, and DONE with ready_o=1 after edge N+DATA_W+1 (N+33 for DATA_W=32).
- **Divide by zero**: BYZERO after N; DONE with ready_o=1 after N+1.
- **Stall window**: stallreq_o=1 from the cycle start_i rises through the last cycle before ready_o=1. It drops in the same cycle as annul_i.
- **Back-to-back divides**: start_i must return to 0 for at least one cycle, so DONE can return to IDLE before the next start.
- **Annul and completion on the same edge**: on the edge where cnt==DATA_W with annul_i=1, annul wins and ready_o stays 0.

## Test plan
- **Unsigned divide**: DIVU 7/2, start held → ready_o=1 exactly 33 cycles after the start edge; result_o=0x00000001_00000003; stallreq_o=1 for 33 cycles.
- **Signed, negative dividend**: DIV -7/2 (0xFFFFFFF9/0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD. DIV 7/-2 → 0x00000001_FFFFFFFD.
- **Signed overflow**: DIV 0x80000000/0xFFFFFFFF → 0x00000000_80000000. DIVU 0xFFFFFFFF/0x00000001 → 0x00000000_FFFFFFFF.
- **Divide by zero**: divisor 0 → ready_o=1 two edges after start, result_o=0. Then start_i=0 → ready_o=0 next edge.
- **Annul mid-divide**: annul_i pulsed at RUN cnt=10 → stallreq_o=0 the same cycle, IDLE next edge, ready_o never rises. A new DIVU 100/7 then yields 0x00000002_0000000E.
- **Reset mid-divide**: rst asserted mid-RUN (async, between edges) → ready_o=0 and result_o=0 immediately. A divide after release has normal 33-cycle latency. Operands changed after the start edge do not affect the result.
